// File: rtl/rtmc_spi_regbus.sv
// SPI mode-0 slave bridging command/address/data frames onto a simple register bus.
// All SPI inputs are resynchronised into clk; sclk must be at most clk/8.
module rtmc_spi_regbus #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdat,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdat,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, BUS, DRAIN} state_t;

  state_t state, state_nxt;

  logic [1:0]    sclk_s, cs_s, mosi_s;
  logic          sclk_d, cs_d;
  logic          cs_q, mosi_q;
  logic          sclk_rise, sclk_fall, cs_fall;

  logic [5:0]    bit_cnt;
  logic [22:0]   sh_in;
  logic [23:0]   nsh;
  logic          wr_frame;
  logic          strobe;
  logic [TW-1:0] tcnt;
  logic [15:0]   miso_sh;
  logic          miso_q;
  logic          counting, launch, bus_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], spi_sclk};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sclk_d <= sclk_s[1];
      cs_d   <= cs_s[1];
    end
  end

  assign cs_q      = cs_s[1];
  assign mosi_q    = mosi_s[1];
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign cs_fall   = cs_d & ~cs_q;
  assign nsh       = {sh_in, mosi_q};

  // Read frames keep counting turnaround bits while the bus transaction runs.
  assign counting = ((state == SHIFT) || ((state == BUS) && !wr_frame))
                    && !cs_q && (bit_cnt < 6'd40);
  assign launch   = (state == SHIFT) && !cs_q && sclk_rise &&
                    (wr_frame ? (bit_cnt == 6'd31) : (bit_cnt == 6'd15));
  assign bus_done = strobe && (reg_ack || (tcnt == TW'(TIMEOUT - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (cs_q)                    state_nxt = IDLE;
        else if (launch)             state_nxt = BUS;
        else if (bit_cnt == 6'd40)   state_nxt = DRAIN;
      end
      BUS: begin
        if (bus_done) begin
          if (cs_q)                               state_nxt = IDLE;
          else if (wr_frame || bit_cnt == 6'd40)  state_nxt = DRAIN;
          else                                    state_nxt = SHIFT;
        end
      end
      DRAIN: if (cs_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    reg_wr      = strobe & wr_frame;
    reg_rd      = strobe & ~wr_frame;
    spi_miso_oe = ~cs_q;
    spi_miso    = miso_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      sh_in    <= '0;
      wr_frame <= 1'b0;
      strobe   <= 1'b0;
      tcnt     <= '0;
      miso_sh  <= '0;
      miso_q   <= 1'b0;
      err      <= 1'b0;
      reg_addr <= '0;
      reg_wdat <= '0;
    end else begin
      if ((state == IDLE) && cs_fall) begin
        bit_cnt  <= '0;
        sh_in    <= '0;
        wr_frame <= 1'b0;
        miso_sh  <= '0;
        err      <= 1'b0;
      end else if (counting && sclk_rise) begin
        bit_cnt <= bit_cnt + 6'd1;
        sh_in   <= nsh[22:0];
        if (bit_cnt == 6'd0) wr_frame <= mosi_q;
      end

      if (launch) begin
        strobe <= 1'b1;
        tcnt   <= '0;
        if (wr_frame) begin
          reg_addr <= ADDR_W'(nsh[23:16]);
          reg_wdat <= DATA_W'(nsh[15:0]);
        end else begin
          reg_addr <= ADDR_W'(nsh[7:0]);
        end
      end else if ((state == BUS) && strobe) begin
        if (reg_ack) begin
          strobe <= 1'b0;
          if (!wr_frame) miso_sh <= 16'(reg_rdat);
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          strobe <= 1'b0;
          err    <= 1'b1;
          if (!wr_frame) miso_sh <= '1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end

      // Data bit n+1 must be on MISO after the falling edge that follows bit n.
      if (cs_q) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        if (!wr_frame && (state != IDLE) && (bit_cnt >= 6'd24) && (bit_cnt < 6'd40)) begin
          miso_q  <= miso_sh[15];
          miso_sh <= {miso_sh[14:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtmc_spi_regbus.sv
// Bench for rtmc_spi_regbus: SPI master tasks, acking responder and a transaction scoreboard.
module tb_rtmc_spi_regbus;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdat;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_rdat = '0;
  logic        reg_ack = 1'b0;
  logic        busy, err;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } txn_t;
  txn_t exp_q[$];

  logic        ack_en = 1'b1;
  logic [15:0] rd_value = '0;
  int          lat = 0;
  logic        prev_strobe = 1'b0;
  logic        prev_ack = 1'b0;
  int          strobe_len = 0;
  int          last_len = 0;
  int          n_strobes = 0;

  rtmc_spi_regbus #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdat(reg_wdat), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdat(reg_rdat), .reg_ack(reg_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor first, then responder, in one process so they see the same sample.
  always @(negedge clk) begin
    logic strobe;
    txn_t t;
    strobe = reg_wr | reg_rd;
    if (reg_wr && reg_rd) begin
      total++; bad++;
      $display("FAIL strobe_excl: wr=%b rd=%b, required not both", reg_wr, reg_rd);
    end
    if (strobe && !prev_strobe) begin
      strobe_len = 1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_txn: wr=%b addr=%h", reg_wr, reg_addr);
      end else begin
        t = exp_q.pop_front();
        total++;
        if (reg_wr !== t.wr) begin
          bad++; $display("FAIL txn_kind: got wr=%b required %b", reg_wr, t.wr);
        end
        total++;
        if (reg_addr !== t.addr) begin
          bad++; $display("FAIL txn_addr: got %h required %h", reg_addr, t.addr);
        end
        if (t.wr) begin
          total++;
          if (reg_wdat !== t.data) begin
            bad++; $display("FAIL txn_wdat: got %h required %h", reg_wdat, t.data);
          end
        end
      end
    end else if (strobe) begin
      strobe_len++;
    end
    if (!strobe && prev_strobe) begin
      last_len = strobe_len;
      n_strobes++;
    end
    if (prev_ack && rst_n) begin
      total++;
      if (strobe !== 1'b0) begin
        bad++; $display("FAIL strobe_after_ack: strobe=%b required 0", strobe);
      end
    end
    prev_strobe = strobe;
    prev_ack = reg_ack;

    if (!rst_n) begin
      reg_ack = 1'b0; lat = 0;
    end else if (strobe && !reg_ack) begin
      if (ack_en) begin
        if (lat == 1) begin
          reg_ack = 1'b1; reg_rdat = rd_value; lat = 0;
        end else begin
          lat++;
        end
      end
    end else begin
      reg_ack = 1'b0; lat = 0;
    end
  end

  task automatic spi_bits(input logic [39:0] bits, input int n,
                          output logic [39:0] mb, output logic oe_ok);
    mb = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[39-i];
      #HALF;
      spi_sclk = 1'b1;
      mb[39-i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [39:0] bits, input int n,
                           output logic [39:0] mb, output logic oe_ok);
    spi_cs_n = 1'b0;
    #HALF;
    spi_bits(bits, n, mb, oe_ok);
    #HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(8*HALF);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int extra);
    logic [39:0] mb;
    logic oe_ok;
    int n0;
    n0 = n_strobes;
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
    spi_frame({8'h80, a, d, 8'hFF}, 32 + extra, mb, oe_ok);
    total++;
    if (n_strobes - n0 != 1) begin
      bad++; $display("FAIL wr_count: got %0d strobes required 1", n_strobes - n0);
    end
    total++;
    if (reg_addr !== a || reg_wdat !== d) begin
      bad++; $display("FAIL wr_hold: got %h/%h required %h/%h", reg_addr, reg_wdat, a, d);
    end
    total++;
    if (last_len != 2) begin
      bad++; $display("FAIL wr_len: got %0d cycles required 2", last_len);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL wr_end: busy=%b err=%b required 0/0", busy, err);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [15:0] exp_d,
                         input logic exp_err, input int exp_len);
    logic [39:0] mb;
    logic oe_ok;
    int n0;
    n0 = n_strobes;
    exp_q.push_back('{wr: 1'b0, addr: a, data: 16'h0});
    spi_frame({8'h00, a, 8'h00, 16'h0000}, 40, mb, oe_ok);
    total++;
    if (mb[15:0] !== exp_d) begin
      bad++; $display("FAIL rd_miso_data: got %h required %h", mb[15:0], exp_d);
    end
    total++;
    if (mb[39:16] !== 24'h0) begin
      bad++; $display("FAIL rd_miso_pre: got %h required 000000", mb[39:16]);
    end
    total++;
    if (oe_ok !== 1'b1 || spi_miso_oe !== 1'b0) begin
      bad++; $display("FAIL rd_oe: in_frame_ok=%b after=%b required 1/0", oe_ok, spi_miso_oe);
    end
    total++;
    if (n_strobes - n0 != 1 || last_len != exp_len) begin
      bad++; $display("FAIL rd_strobe: count=%0d len=%0d required 1/%0d",
                      n_strobes - n0, last_len, exp_len);
    end
    total++;
    if (err !== exp_err || busy !== 1'b0) begin
      bad++; $display("FAIL rd_end: err=%b busy=%b required %b/0", err, busy, exp_err);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({spi_miso, spi_miso_oe, reg_addr, reg_wdat, reg_wr, reg_rd, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: miso=%b oe=%b addr=%h wdat=%h wr=%b rd=%b busy=%b err=%b, required all 0",
               spi_miso, spi_miso_oe, reg_addr, reg_wdat, reg_wr, reg_rd, busy, err);
    end
  endtask

  task automatic test_write();
    do_write(8'h05, 16'h1234, 0);
  endtask

  task automatic test_read();
    rd_value = 16'h0142;
    do_read(8'h00, 16'h0142, 1'b0, 2);
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    do_read(8'h33, 16'hFFFF, 1'b1, 15);
    ack_en = 1'b1;
    spi_cs_n = 1'b0;
    #(8*10);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL err_clear: err=%b busy=%b required 0/1", err, busy);
    end
    spi_cs_n = 1'b1;
    #(8*HALF);
  endtask

  task automatic test_abort();
    logic [39:0] mb;
    logic oe_ok;
    int n0;
    n0 = n_strobes;
    spi_frame({8'h80, 8'h77, 16'h5555, 8'h00}, 20, mb, oe_ok);
    total++;
    if (n_strobes != n0) begin
      bad++; $display("FAIL abort_no_wr: got %0d strobes required 0", n_strobes - n0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy: got %b required 0", busy);
    end
    total++;
    if (reg_wdat !== 16'h1234) begin
      bad++; $display("FAIL abort_hold: wdat=%h required 1234", reg_wdat);
    end
  endtask

  task automatic test_extra_bits();
    do_write(8'h11, 16'hCAFE, 4);
  endtask

  task automatic test_back_to_back();
    do_write(8'hA5, 16'hBEEF, 0);
    rd_value = 16'h5A5A;
    do_read(8'hA5, 16'h5A5A, 1'b0, 2);
    total++;
    if (reg_addr !== 8'hA5 || reg_wdat !== 16'hBEEF) begin
      bad++; $display("FAIL b2b_hold: got %h/%h required a5/beef", reg_addr, reg_wdat);
    end
    do_write(8'h3C, 16'h0F0F, 0);
  endtask

  task automatic test_reset_mid();
    logic [39:0] mb;
    logic oe_ok;
    bit seen;
    ack_en = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: 8'h44, data: 16'h0});
    spi_cs_n = 1'b0;
    #HALF;
    spi_bits({8'h00, 8'h44, 24'h0}, 16, mb, oe_ok);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (reg_rd === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL mid_rd_seen: reg_rd never rose, required 1");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (reg_rd !== 1'b0 || spi_miso_oe !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: rd=%b oe=%b busy=%b required 0/0/0", reg_rd, spi_miso_oe, busy);
    end
    #1;
    spi_cs_n = 1'b1;
    #40;
    rst_n = 1'b1;
    ack_en = 1'b1;
    #(4*HALF);
    do_write(8'h66, 16'h7777, 0);
  endtask

  initial begin
    #2;
    #40;
    test_reset();
    rst_n = 1'b1;
    #100;
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_extra_bits();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/rtmc_spi_regbus.md
RTMC_SPI_REGBUS -- requirements
Module: rtmc_spi_regbus

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register bus address width.
REQ-002 SHALL have parameter DATA_W, default 16, register bus data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max clk cycles to wait for reg_ack.
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active-low.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out.
- spi_miso_oe  out  1  MISO output enable.
- reg_addr  out  ADDR_W  bus address.
- reg_wdat  out  DATA_W  bus write data.
- reg_wr  out  1  write strobe.
- reg_rd  out  1  read strobe.
- reg_rdat  in  DATA_W  bus read data, valid when reg_ack=1.
- reg_ack  in  1  bus acknowledge.
- busy  out  1  frame or bus transaction in progress.
- err  out  1  sticky bus timeout flag.

Function
REQ-005 spi_sclk, spi_cs_n, spi_mosi SHALL each pass a 2-flop synchronizer; edges detected on synchronized values; supported sclk <= clk/8.
REQ-006 SHALL implement SPI mode 0: MOSI sampled on sclk rising edge, MISO updated on sclk falling edge, MSB first.
REQ-007 Frame: cmd byte (bit7=1 write, 0 read; bits6:0 ignored), then address byte, then for write 16 data bits (32 bits total); for read 8 turnaround bits then 16 data bits (40 bits total).
REQ-008 States SHALL be IDLE, SHIFT, BUS, DRAIN; IDLE->SHIFT on synchronized cs_n falling edge, clearing bit counter and err.
REQ-009 Write: on 32nd rising edge, SHIFT->BUS, reg_addr/reg_wdat loaded, reg_wr=1 next cycle.
REQ-010 Read: on 16th rising edge, BUS entered with reg_rd=1 while bit counting continues; rdat loaded into the MISO shift register on the cycle reg_ack=1 is sampled.
REQ-011 Strobe SHALL deassert on the clk edge at which reg_ack=1 is sampled (one-cycle overlap tolerated); reg_wr and reg_rd never both 1.
REQ-012 If no reg_ack within TIMEOUT cycles of strobe assertion, strobe SHALL deassert, err SHALL set, and read shift data SHALL be 16'hFFFF.
REQ-013 After BUS: write -> DRAIN; read -> SHIFT to continue turnaround/data bits; DRAIN waits for cs_n rise then IDLE.
REQ-014 spi_miso_oe SHALL be 1 while synchronized cs_n=0, else 0; spi_miso SHALL be 0 during cmd/addr/turnaround bits and after bit 40, shift register MSB during read data bits.
REQ-015 cs_n rise mid-frame SHALL abort: no new bus transaction issued; a strobe already asserted SHALL complete (ack or timeout) before IDLE.
REQ-016 Bits after frame end (before cs_n rise) SHALL be ignored.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 reg_addr/reg_wdat SHALL hold last values until next load.

Reset
REQ-019 On rst_n=0 all outputs SHALL be 0, state IDLE, counters, shift registers and synchronizers cleared; sync flop for cs_n resets to 1.
REQ-020 Reset mid-frame or mid-transaction SHALL drop strobes immediately; following frame SHALL decode from bit 0.

Verification
REQ-021 Write frame 0x80,0x05,0x1234 -> one reg_wr with reg_addr=0x05, reg_wdat=0x1234, dropped the cycle after reg_ack=1.
REQ-022 Read frame 0x00,0x00,dummy, responder returns 0x0142 -> reg_rd once, MISO bits 25..40 = 0x0142 MSB first.
REQ-023 Read with reg_ack tied 0 -> strobe drops after 15 cycles, err=1, MISO data 0xFFFF; err clears at next cs_n fall.
REQ-024 cs_n raised after 20 bits of a write frame -> no reg_wr, busy returns to 0.
REQ-025 Back-to-back frames with cs_n high 4 sclk periods -> both transactions correct, no bit leakage between frames.
REQ-026 rst_n asserted during reg_rd high -> reg_rd=0, miso_oe=0 same cycle; next write frame executes correctly.
